// File: rtl/i2c_defines.sv
//==============================================================================
// Module      : i2c_defines (package)
// Description : Shared register addresses, CTR/CR/SR bit indices and reset
//               constants for the I2C Wishbone register front-end.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

package i2c_defines;

    // Wishbone register addresses
    localparam logic [2:0] c_ADR_PRERLO = 3'd0;
    localparam logic [2:0] c_ADR_PRERHI = 3'd1;
    localparam logic [2:0] c_ADR_CTR    = 3'd2;
    localparam logic [2:0] c_ADR_TXRX   = 3'd3;   // write TXR / read RXR
    localparam logic [2:0] c_ADR_CRSR   = 3'd4;   // write CR  / read SR

    // CTR bit indices
    localparam int c_CTR_EN   = 7;
    localparam int c_CTR_IEN  = 6;
    localparam int c_CTR_SRST = 0;

    // CR bit indices
    localparam int c_CR_START = 7;
    localparam int c_CR_STOP  = 6;
    localparam int c_CR_READ  = 5;
    localparam int c_CR_WRITE = 4;
    localparam int c_CR_IACK  = 0;

    // Status bit index of arbitration-lost
    localparam int c_ST_AL = 5;

    // Prescaler reset value
    localparam logic [15:0] c_PRER_RST = 16'hFFFF;

endpackage

`default_nettype wire

// File: rtl/i2c_prescaler.sv
//==============================================================================
// Module      : i2c_prescaler
// Description : 16-bit down-counter reloaded from PRER. Emits a one-cycle
//               tick every PRER+1 clocks while enabled; PRER=0 gives a
//               constant-high tick. Disabled: counter held at PRER, tick=0.
// Ports       : clk   - clock
//               rst_  - asynchronous active-low reset
//               en    - prescaler enable (CTR.EN)
//               prer  - reload value
//               tick  - prescaler tick output
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module i2c_prescaler
    import i2c_defines::*;
(
    input  logic        clk,
    input  logic        rst_,
    input  logic        en,
    input  logic [15:0] prer,
    output logic        tick
);

    logic [15:0] r_cnt;
    logic        r_tick;
    logic        w_zero;

    assign w_zero = (r_cnt == 16'd0);

    // While disabled the counter sits at PRER, so the first tick after
    // enabling lands exactly PRER+1 cycles later.
    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            r_cnt  <= c_PRER_RST;
            r_tick <= 1'b0;
        end else if (!en) begin
            r_cnt  <= prer;
            r_tick <= 1'b0;
        end else begin
            r_tick <= w_zero;
            r_cnt  <= w_zero ? prer : (r_cnt - 16'd1);
        end
    end

    // Gate with en so the tick drops in the same cycle EN is cleared.
    assign tick = r_tick & en;

endmodule

`default_nettype wire

// File: rtl/i2c_wb_regs.sv
//==============================================================================
// Module      : i2c_wb_regs
// Description : Wishbone register front-end for an I2C master core.
//               Holds PRER, CTR, TXR, RXR, CR, the interrupt flag, and the
//               clock prescaler; single-cycle acked Wishbone slave.
// Ports       : clk, rst_             - clock, async active-low reset
//               wb_*                  - Wishbone slave (adr 3b, data 8b)
//               din/cmd/wr_en         - TXR, CR, transmit-pending to core
//               master/nReset/scl_gen - CTR.EN, soft reset pulse, tick
//               dout/status           - received byte and core status
//               wr_done/rd_done       - byte transfer completion pulses
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module i2c_wb_regs
    import i2c_defines::*;
(
    input  logic       clk,
    input  logic       rst_,
    // Wishbone slave
    input  logic [2:0] wb_adr_i,
    input  logic [7:0] wb_dat_i,
    output logic [7:0] wb_dat_o,
    input  logic       wb_we_i,
    input  logic       wb_stb_i,
    input  logic       wb_cyc_i,
    output logic       wb_ack_o,
    output logic       wb_inta_o,
    // Core side
    output logic [7:0] din,
    output logic [7:0] cmd,
    output logic       wr_en,
    output logic       master,
    output logic       nReset,
    output logic       scl_gen,
    input  logic [7:0] dout,
    input  logic [7:0] status,
    input  logic       wr_done,
    input  logic       rd_done
);

    logic        r_ack;
    logic        r_bus_hold;
    logic [7:0]  r_dat_o;
    logic [15:0] r_prer;
    logic        r_en;
    logic        r_ien;
    logic [7:0]  r_txr;
    logic [7:0]  r_rxr;
    logic [3:0]  r_cmd;
    logic        r_wr_en;
    logic        r_irq;
    logic        r_nreset;
    logic        r_al_d;

    logic        w_req;
    logic        w_acc;
    logic        w_wr;
    logic        w_wr_prlo;
    logic        w_wr_prhi;
    logic        w_wr_ctr;
    logic        w_wr_txr;
    logic        w_wr_cr;
    logic        w_srst;
    logic        w_iack;
    logic        w_al_rise;
    logic        w_cmd_clr;
    logic        w_irq_set;
    logic        w_tick;
    logic [7:0]  w_rd_data;

    //--------------------------------------------------------------------------
    // Bus decode
    //--------------------------------------------------------------------------
    assign w_req = wb_cyc_i & wb_stb_i;
    // r_bus_hold is set by reset and released once the bus goes idle, so a
    // strobe left over from an access interrupted by reset is never
    // re-accepted after reset release.
    assign w_acc = w_req & ~r_ack & ~r_bus_hold;
    assign w_wr  = w_acc & wb_we_i;

    assign w_wr_prlo = w_wr & (wb_adr_i == c_ADR_PRERLO) & ~r_en;
    assign w_wr_prhi = w_wr & (wb_adr_i == c_ADR_PRERHI) & ~r_en;
    assign w_wr_ctr  = w_wr & (wb_adr_i == c_ADR_CTR);
    assign w_wr_txr  = w_wr & (wb_adr_i == c_ADR_TXRX);
    assign w_wr_cr   = w_wr & (wb_adr_i == c_ADR_CRSR);
    assign w_srst    = w_wr_ctr & wb_dat_i[c_CTR_SRST];
    assign w_iack    = w_wr_cr & wb_dat_i[c_CR_IACK];

    assign w_al_rise = status[c_ST_AL] & ~r_al_d;
    assign w_cmd_clr = rd_done | wr_done | w_al_rise | ~r_en;
    assign w_irq_set = rd_done | wr_done | w_al_rise;

    always_comb begin
        w_rd_data = 8'h00;
        case (wb_adr_i)
            c_ADR_PRERLO: w_rd_data = r_prer[7:0];
            c_ADR_PRERHI: w_rd_data = r_prer[15:8];
            c_ADR_CTR:    w_rd_data = {r_en, r_ien, 6'b000000};
            c_ADR_TXRX:   w_rd_data = r_rxr;
            c_ADR_CRSR:   w_rd_data = {status[7:1], r_irq};
            default:      w_rd_data = 8'h00;
        endcase
    end

    //--------------------------------------------------------------------------
    // Wishbone handshake
    //--------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            r_ack      <= 1'b0;
            r_bus_hold <= 1'b1;
            r_dat_o    <= 8'h00;
        end else begin
            r_ack <= w_acc;
            if (!w_req) begin
                r_bus_hold <= 1'b0;
            end
            if (w_acc) begin
                r_dat_o <= w_rd_data;
            end
        end
    end

    //--------------------------------------------------------------------------
    // Configuration registers (untouched by soft reset)
    //--------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            r_prer <= c_PRER_RST;
            r_en   <= 1'b0;
            r_ien  <= 1'b0;
            r_txr  <= 8'h00;
            r_rxr  <= 8'h00;
        end else begin
            if (w_wr_prlo) begin
                r_prer[7:0] <= wb_dat_i;
            end
            if (w_wr_prhi) begin
                r_prer[15:8] <= wb_dat_i;
            end
            if (w_wr_ctr) begin
                r_en  <= wb_dat_i[c_CTR_EN];
                r_ien <= wb_dat_i[c_CTR_IEN];
            end
            if (w_wr_txr) begin
                r_txr <= wb_dat_i;
            end
            if (rd_done) begin
                r_rxr <= dout;
            end
        end
    end

    //--------------------------------------------------------------------------
    // Command, transmit-pending, interrupt and soft-reset state
    //--------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            r_cmd    <= 4'h0;
            r_wr_en  <= 1'b0;
            r_irq    <= 1'b0;
            r_nreset <= 1'b0;
            r_al_d   <= 1'b0;
        end else begin
            r_nreset <= w_srst;
            r_al_d   <= status[c_ST_AL];

            if (w_srst) begin
                r_cmd   <= 4'h0;
                r_wr_en <= 1'b0;
                r_irq   <= 1'b0;
            end else begin
                // A CR write beats any simultaneous clear condition.
                if (w_wr_cr) begin
                    r_cmd <= wb_dat_i[c_CR_START:c_CR_WRITE];
                end else if (w_cmd_clr) begin
                    r_cmd <= 4'h0;
                end

                // A TXR write beats a simultaneous wr_done.
                if (w_wr_txr) begin
                    r_wr_en <= 1'b1;
                end else if (wr_done) begin
                    r_wr_en <= 1'b0;
                end

                // A new event beats a simultaneous IACK.
                if (w_irq_set) begin
                    r_irq <= 1'b1;
                end else if (w_iack) begin
                    r_irq <= 1'b0;
                end
            end
        end
    end

    //--------------------------------------------------------------------------
    // Prescaler
    //--------------------------------------------------------------------------
    i2c_prescaler u_prescaler (
        .clk  (clk),
        .rst_ (rst_),
        .en   (r_en),
        .prer (r_prer),
        .tick (w_tick)
    );

    //--------------------------------------------------------------------------
    // Outputs
    //--------------------------------------------------------------------------
    assign wb_ack_o  = r_ack;
    assign wb_dat_o  = r_dat_o;
    assign wb_inta_o = r_irq & r_ien;
    assign din       = r_txr;
    assign cmd       = {r_cmd, 4'b0000};
    assign wr_en     = r_wr_en;
    assign master    = r_en;
    assign nReset    = r_nreset;
    assign scl_gen   = w_tick;

endmodule

`default_nettype wire

// File: doc/i2c_wb_regs.md
I2C_WB_REGS -- requirements
Module: i2c_wb_regs

Interface
REQ-001 SHALL have ports `clk` (input, 1, sole clock) and `rst_` (input, 1, asynchronous active-low reset).
REQ-002 SHALL have Wishbone slave ports `wb_adr_i` (in, 3), `wb_dat_i` (in, 8), `wb_dat_o` (out, 8), `wb_we_i`, `wb_stb_i`, `wb_cyc_i` (in, 1), and `wb_ack_o`, `wb_inta_o` (out, 1).
REQ-003 SHALL have core-side outputs `din` (8, TXR), `cmd` (8, CR), `wr_en` (1), `master` (1, CTR.EN), `nReset` (1, soft reset pulse) and `scl_gen` (1, prescaler tick).
REQ-004 SHALL have core-side inputs `dout` (8, received byte), `status` (8: ack, busy, al, cmd_ack, 0, 0, transfer, int), `wr_done` (1) and `rd_done` (1).

Function
REQ-005 Register map: 0 PRERlo, 1 PRERhi, 2 CTR (bit7 EN, bit6 IEN, bit0 SRST), 3 write TXR / read RXR, 4 write CR / read SR, 5-7 reserved.
REQ-006 An access SHALL be accepted when `wb_cyc_i & wb_stb_i & ~wb_ack_o`.
REQ-007 `wb_ack_o` SHALL assert in the cycle after acceptance, for exactly one cycle; it is never high two consecutive cycles.
REQ-008 Writes SHALL take effect on the edge that asserts `wb_ack_o`; `wb_dat_o` SHALL be valid while `wb_ack_o` is high.
REQ-009 Reserved addresses SHALL read 0x00, ignore writes, and still be acked.
REQ-010 PRERlo/PRERhi writes SHALL be ignored while EN=1.
REQ-011 CTR.SRST SHALL read 0. Writing 1 SHALL drive `nReset` high for exactly one cycle and clear `cmd`, `wr_en` and the irq flag.
REQ-012 CR reads back as `cmd[7:4]`, with bits [3:0] reading 0. CR bit0 (IACK) SHALL clear the irq flag and never be stored.
REQ-013 CR bits [7:4] (START, STOP, READ, WRITE) SHALL hold until cleared by any of: a `rd_done` pulse, a `wr_done` pulse, a rising edge of `status[5]` (al), or EN=0.
REQ-014 A CR write in the same cycle as a clear condition SHALL win (new value stored).
REQ-015 A TXR write SHALL set `wr_en`; a `wr_done` pulse SHALL clear it; a TXR write coincident with `wr_done` SHALL leave `wr_en`=1.
REQ-016 RXR SHALL capture `dout` on the edge where `rd_done`=1; otherwise RXR holds.
REQ-017 The irq flag SHALL be set by `rd_done`, `wr_done`, or a rising edge of al; set SHALL win over a simultaneous IACK.
REQ-018 `wb_inta_o` SHALL equal irq flag AND CTR.IEN.
REQ-019 An SR read SHALL return `{status[7:1], irq flag}`.
REQ-020 Prescaler: a 16-bit down-counter reloaded with PRER. `scl_gen` SHALL pulse for one cycle every PRER+1 clk cycles while EN=1.
REQ-021 PRER=0 SHALL make `scl_gen` constant high while EN=1.
REQ-022 With EN=0, the prescaler counter SHALL be held at PRER and `scl_gen` SHALL be 0; the first tick after EN 0->1 SHALL occur PRER+1 cycles later.
REQ-023 `master` SHALL equal CTR.EN.

Reset
REQ-024 When `rst_`=0, all state SHALL clear asynchronously: PRER=0xFFFF; CTR, TXR, RXR, CR = 0x00; `wr_en`, irq flag, `wb_ack_o`, `wb_inta_o`, `scl_gen`, `nReset` = 0; `wb_dat_o` = 0x00.
REQ-025 Reset asserted mid-access SHALL drop `wb_ack_o` immediately. The access is lost, and no write SHALL take effect after reset release.
REQ-026 `nReset` (soft reset) SHALL NOT affect PRER, CTR.EN/IEN, TXR or RXR.

Structure
REQ-027 Register addresses, CTR bit indices and CR command bit indices SHALL reside in the shared `i2c_defines` package.
REQ-028 The prescaler SHALL be a sub-module `i2c_prescaler` (inputs clk, rst_, en, prer[15:0]; output tick).

Verification
REQ-029 Reset -> read addr 0/1/2 -> 0xFF, 0xFF, 0x00. Each ack is one cycle high, arriving one cycle after stb.
REQ-030 PRER=0x0003, CTR=0x80 -> `scl_gen` pulses every 4 clk cycles. Then write PRERlo=0x09 while EN=1 -> ignored, period stays 4.
REQ-031 TXR=0xA5, CR=0x90 -> `din`=0xA5, `wr_en`=1, `cmd`=0x90. Then `wr_done` pulse -> `wr_en`=0, CR reads 0x00, SR bit0=1.
REQ-032 CTR=0xC0, CR=0x20, `dout`=0x3C, `rd_done` pulse -> RXR reads 0x3C, `wb_inta_o`=1. Then CR=0x01 -> `wb_inta_o`=0.
REQ-033 `rd_done` and IACK write in the same cycle -> irq flag remains 1. Then `status[5]` 0->1 with `cmd`=0x80 -> CR clears to 0x00.
REQ-034 CTR=0x81 -> `nReset` high for exactly one cycle, CTR reads 0x80, `cmd`=0, `wr_en`=0. Assert `rst_` during an ack cycle -> `wb_ack_o` drops the same cycle.
